// File: rtl/vga_gfx_pkg.sv
// Shared tile ids, sprite sheet geometry and hit-box margins for the VGA
// sprite/tile address path.
package vga_gfx_pkg;

    typedef enum logic [3:0] {
        TILE_EMPTY   = 4'd0,
        TILE_GATE_1  = 4'd1,
        TILE_GATE_2  = 4'd2,
        TILE_GATE_3  = 4'd3,
        TILE_PLATE_1 = 4'd4,
        TILE_PLATE_2 = 4'd5,
        TILE_PLATE_3 = 4'd6,
        TILE_EXIT    = 4'd7,
        TILE_WALL    = 4'd8
    } tile_id_t;

    localparam int unsigned EXIT_BASE   = 11264;
    localparam int unsigned GATE_BASE   = 12288;

    localparam int unsigned IDLE_BASE   = 1024;
    localparam int unsigned IDLE_WIDTH  = 128;
    localparam int unsigned IDLE_FRAMES = 4;
    localparam int unsigned WALK_BASE   = 5120;
    localparam int unsigned WALK_WIDTH  = 192;
    localparam int unsigned WALK_FRAMES = 6;

    localparam int unsigned HIT_MARGIN_L = 3;
    localparam int unsigned HIT_MARGIN_R = 3;
    localparam int unsigned HIT_MARGIN_T = 5;

    typedef struct packed {
        logic       show;
        logic [3:0] tile_id;
        logic       is_char;
        logic [2:0] spr_idx;
    } ctrl_t;

    // WALL and PLATE share the top of the sheet; unknown ids map there too.
    function automatic int unsigned tile_base(input logic [3:0] id);
        case (id)
            TILE_GATE_1, TILE_GATE_2, TILE_GATE_3: tile_base = GATE_BASE;
            TILE_EXIT:                             tile_base = EXIT_BASE;
            default:                               tile_base = 0;
        endcase
    endfunction

endpackage

// File: rtl/sprite_hit_unit.sv
// Per-sprite hit-box test and sheet-local coordinates derived from the
// shadowed sprite state.
module sprite_hit_unit
    import vga_gfx_pkg::*;
#(
    parameter int SPR_W  = 32,
    parameter int SPR_H  = 32,
    parameter int ADDR_W = 17
) (
    input  logic [9:0]        h_cnt,
    input  logic [9:0]        v_cnt,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic [2:0]        frame,
    input  logic              moving,
    input  logic              face_left,
    input  logic              en,
    output logic              hit,
    output logic [ADDR_W-1:0] lx,
    output logic [ADDR_W-1:0] ly
);

    logic [10:0]       h11, v11, x11, y11;
    logic              hit_x, hit_y;
    logic [ADDR_W-1:0] rel;
    int unsigned       fcount;
    logic [2:0]        f;

    always_comb begin
        // 11-bit compares so a sprite near the right edge never wraps to h=0.
        h11    = {1'b0, h_cnt};
        v11    = {1'b0, v_cnt};
        x11    = {1'b0, x};
        y11    = {1'b0, y};
        hit_x  = (h11 >= x11 + 11'(HIT_MARGIN_L)) &&
                 (h11 <  x11 + 11'(SPR_W - int'(HIT_MARGIN_R)));
        hit_y  = (v11 >= y11 + 11'(HIT_MARGIN_T)) &&
                 (v11 <  y11 + 11'(SPR_H));
        hit    = en & hit_x & hit_y;

        rel    = ADDR_W'(h_cnt) - ADDR_W'(x);
        fcount = moving ? WALK_FRAMES : IDLE_FRAMES;
        f      = (32'(frame) >= fcount) ? 3'd0 : frame;
        lx     = (face_left ? ADDR_W'(SPR_W - 1) - rel : rel) +
                 ADDR_W'(f) * ADDR_W'(SPR_W);
        ly     = ADDR_W'(v_cnt) - ADDR_W'(y);
    end

endmodule

// File: rtl/sprite_tile_addr_gen.sv
// Resolves tile map and sprites into one BRAM read address per pixel and
// delays the matching control flags to line up with the BRAM colour data.
module sprite_tile_addr_gen
    import vga_gfx_pkg::*;
#(
    parameter int NUM_SPR       = 2,
    parameter int SPR_W         = 32,
    parameter int SPR_H         = 32,
    parameter int TILE_SHIFT    = 5,
    parameter int MAP_COLS      = 20,
    parameter int MAP_ROWS      = 15,
    parameter int ADDR_W        = 17,
    parameter int BRAM_LAT      = 2,
    parameter int SPR_OVER_TILE = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [9:0]              h_cnt,
    input  logic [9:0]              v_cnt,
    input  logic                    vsync,
    input  logic [10*NUM_SPR-1:0]   spr_x,
    input  logic [10*NUM_SPR-1:0]   spr_y,
    input  logic [3*NUM_SPR-1:0]    spr_frame,
    input  logic [NUM_SPR-1:0]      spr_moving,
    input  logic [NUM_SPR-1:0]      spr_face_left,
    input  logic [NUM_SPR-1:0]      spr_en,
    input  logic [2:0]              gate_open,
    input  logic                    map_we,
    input  logic [8:0]              map_waddr,
    input  logic [3:0]              map_wdata,
    output logic [ADDR_W-1:0]       pixel_addr,
    output logic                    out_show_pixel,
    output logic [3:0]              out_tile_id,
    output logic                    out_is_char_sync,
    output logic [2:0]              out_spr_idx
);

    localparam int unsigned MAP_N = MAP_COLS * MAP_ROWS;
    localparam int unsigned TS    = TILE_SHIFT;

    logic                  vsync_q, vsync_d, vsync_edge;
    logic [10*NUM_SPR-1:0] sh_x_q, sh_x_d, sh_y_q, sh_y_d;
    logic [3*NUM_SPR-1:0]  sh_frame_q, sh_frame_d;
    logic [NUM_SPR-1:0]    sh_moving_q, sh_moving_d;
    logic [NUM_SPR-1:0]    sh_face_q, sh_face_d;
    logic [NUM_SPR-1:0]    sh_en_q, sh_en_d;
    logic [3:0]            map_q [MAP_N];
    logic [3:0]            map_d [MAP_N];
    logic [ADDR_W-1:0]     pixel_addr_q, pixel_addr_d;
    ctrl_t                 ctrl_q [BRAM_LAT+1];
    ctrl_t                 ctrl_d [BRAM_LAT+1];

    always_comb begin
        vsync_d     = vsync;
        vsync_edge  = vsync & ~vsync_q;
        sh_x_d      = sh_x_q;
        sh_y_d      = sh_y_q;
        sh_frame_d  = sh_frame_q;
        sh_moving_d = sh_moving_q;
        sh_face_d   = sh_face_q;
        sh_en_d     = sh_en_q;
        if (vsync_edge) begin
            sh_x_d      = spr_x;
            sh_y_d      = spr_y;
            sh_frame_d  = spr_frame;
            sh_moving_d = spr_moving;
            sh_face_d   = spr_face_left;
            sh_en_d     = spr_en;
        end
        map_d = map_q;
        if (map_we && (32'(map_waddr) < MAP_N))
            map_d[map_waddr] = map_wdata;
    end

    // Sprite hit units
    logic [NUM_SPR-1:0] hit;
    logic [ADDR_W-1:0]  lx_a [NUM_SPR];
    logic [ADDR_W-1:0]  ly_a [NUM_SPR];

    for (genvar g = 0; g < NUM_SPR; g++) begin : g_spr
        sprite_hit_unit #(
            .SPR_W  (SPR_W),
            .SPR_H  (SPR_H),
            .ADDR_W (ADDR_W)
        ) u_hit (
            .h_cnt     (h_cnt),
            .v_cnt     (v_cnt),
            .x         (sh_x_q[10*g +: 10]),
            .y         (sh_y_q[10*g +: 10]),
            .frame     (sh_frame_q[3*g +: 3]),
            .moving    (sh_moving_q[g]),
            .face_left (sh_face_q[g]),
            .en        (sh_en_q[g]),
            .hit       (hit[g]),
            .lx        (lx_a[g]),
            .ly        (ly_a[g])
        );
    end

    logic              visible, gate_is_open, tile_solid;
    logic [8:0]        rd_idx;
    logic [3:0]        tile_id;
    logic [ADDR_W-1:0] tile_addr, spr_addr, sel_lx, sel_ly;
    logic              any_hit, sel_moving, use_tile, use_spr;
    logic [2:0]        sel_idx;

    always_comb begin
        visible = (h_cnt < 10'd640) && (v_cnt < 10'd480);
        rd_idx  = 9'(32'(v_cnt >> TS) * MAP_COLS + 32'(h_cnt >> TS));
        tile_id = (visible && (32'(rd_idx) < MAP_N)) ? map_q[rd_idx] : TILE_EMPTY;
        case (tile_id)
            TILE_GATE_1: gate_is_open = gate_open[0];
            TILE_GATE_2: gate_is_open = gate_open[1];
            TILE_GATE_3: gate_is_open = gate_open[2];
            default:     gate_is_open = 1'b0;
        endcase
        tile_solid = (tile_id != TILE_EMPTY) && !gate_is_open;
        tile_addr  = ADDR_W'(tile_base(tile_id)) +
                     (ADDR_W'(v_cnt[TS-1:0]) << TS) + ADDR_W'(h_cnt[TS-1:0]);

        any_hit    = 1'b0;
        sel_idx    = 3'd0;
        sel_lx     = '0;
        sel_ly     = '0;
        sel_moving = 1'b0;
        for (int unsigned i = 0; i < NUM_SPR; i++) begin
            if (hit[i] && !any_hit) begin
                any_hit    = 1'b1;
                sel_idx    = 3'(i);
                sel_lx     = lx_a[i];
                sel_ly     = ly_a[i];
                sel_moving = sh_moving_q[i];
            end
        end
        spr_addr = sel_moving
                 ? ADDR_W'(WALK_BASE) + sel_ly * ADDR_W'(WALK_WIDTH) + sel_lx
                 : ADDR_W'(IDLE_BASE) + sel_ly * ADDR_W'(IDLE_WIDTH) + sel_lx;

        use_tile = tile_solid && ((SPR_OVER_TILE == 0) || !any_hit);
        use_spr  = any_hit && !use_tile;

        if (use_tile)     pixel_addr_d = tile_addr;
        else if (use_spr) pixel_addr_d = spr_addr;
        else              pixel_addr_d = '0;

        ctrl_d[0].show    = tile_solid | any_hit;
        ctrl_d[0].tile_id = tile_id;
        ctrl_d[0].is_char = use_spr;
        ctrl_d[0].spr_idx = use_spr ? sel_idx : 3'd0;
        for (int unsigned i = 1; i <= BRAM_LAT; i++)
            ctrl_d[i] = ctrl_q[i-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q      <= 1'b0;
            sh_x_q       <= '0;
            sh_y_q       <= '0;
            sh_frame_q   <= '0;
            sh_moving_q  <= '0;
            sh_face_q    <= '0;
            sh_en_q      <= '0;
            pixel_addr_q <= '0;
            for (int unsigned i = 0; i < MAP_N; i++)
                map_q[i] <= '0;
            for (int unsigned i = 0; i <= BRAM_LAT; i++)
                ctrl_q[i] <= '0;
        end else begin
            vsync_q      <= vsync_d;
            sh_x_q       <= sh_x_d;
            sh_y_q       <= sh_y_d;
            sh_frame_q   <= sh_frame_d;
            sh_moving_q  <= sh_moving_d;
            sh_face_q    <= sh_face_d;
            sh_en_q      <= sh_en_d;
            pixel_addr_q <= pixel_addr_d;
            map_q        <= map_d;
            ctrl_q       <= ctrl_d;
        end
    end

    assign pixel_addr       = pixel_addr_q;
    assign out_show_pixel   = ctrl_q[BRAM_LAT].show;
    assign out_tile_id      = ctrl_q[BRAM_LAT].tile_id;
    assign out_is_char_sync = ctrl_q[BRAM_LAT].is_char;
    assign out_spr_idx      = ctrl_q[BRAM_LAT].spr_idx;

endmodule
